uart_rx: RTL
============

# uart_rx

UART receiver for the 25 MHz ULX3S designs, the downstream counterpart of the UART transmitter. It recovers 8N1 frames at 115200 baud from the asynchronous serial input using 16x oversampling. Each received byte is presented on a parallel output with a one-cycle strobe, and stop-bit failures are flagged. It sits between the FTDI/board RX pin and the byte consumer, such as a command parser or loopback to the transmitter.

## Interface
Parameters:
- `TICK_INC`, default 16'd4832: phase-accumulator increment. Oversample tick rate = f_clk·TICK_INC/2^16 ≈ 1,843,261 Hz, which is 16 × 115200 within 0.01%.
- `OVERSAMPLE`, default 16: ticks per bit. Fixed at 16; the phase counter is 4 bits.

Ports:
- `clk_25mhz` input, 1 bit: single system clock, 25 MHz.
- `resetn` input, 1 bit: asynchronous, active-low reset.
- `rx` input, 1 bit: serial line, idle high, asynchronous to `clk_25mhz`.
- `data` output, 8 bits: last received byte. Held until the next frame completes.
- `valid` output, 1 bit: one-cycle pulse when `data` updates with a good frame.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- Input conditioning:
  - `rx` passes through a 2-flop synchronizer; both flops reset to 1.
  - A third flop holds the previous synchronized value for edge detection.
- Tick generator:
  - 16-bit accumulator; `{tick, acc} <= acc + TICK_INC` every clock.
  - `tick` is high for one clock on each overflow.
  - The accumulator free-runs and resets to 0.
- Bit-phase counter `ph` (4 bits): cleared on start-edge detection, increments on each tick, wraps 15→0.
- Bit counter `nb` (3 bits) indexes data bits LSB first.
- States:
  - IDLE: on a synchronized falling edge (prev=1, cur=0), clear `ph` and go to START. Edges are not detected in any other state.
  - START: at the sample point, if the sampled value is 0, go to DATA with `nb`=0. If it is 1, treat it as a glitch and return to IDLE with no output.
  - DATA: when `ph` wraps, advance to the next bit. At the sample point, shift the sampled value into bit 7 of the shift register (right shift). After the 8th bit's sample point, go to STOP once `ph` wraps.
  - STOP: at the sample point:
    - Sample = 1: load `data` from the shift register, pulse `valid`, go to IDLE.
    - Sample = 0: load `data` anyway, pulse `frame_err` with no `valid`, go to IDLE.
- After a break or `frame_err`, IDLE requires `rx` high and then a falling edge before a new frame starts, so a held-low line produces exactly one error.
- `valid` and `frame_err` are never high in the same cycle.
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE, `ph`=0, `nb`=0, shift register=8'h00, accumulator=0.
- Reset mid-frame: all state is discarded immediately and no strobe is issued. After release, the first falling edge seen is treated as a start bit (a resync may mis-frame; this is accepted).

## Timing
- Synchronizer latency is 2 clocks from `rx` to the edge detector.
- Sample point is the tick where `ph` becomes 7, i.e. the bit centre. Decision timing depends on configuration (see below).
- `valid`/`frame_err` assert on the clock after the STOP decision tick and last exactly 1 clock.
- `busy` rises 1 clock after edge detection. It falls in the same cycle `valid`/`frame_err` asserts.
- End-to-end: the strobe occurs ≈ 9.5 bit times (≈ 2062 clocks) after the start edge at the pin, ±1 tick of jitter.
- Back-to-back frames: IDLE is re-entered about half a bit before the next start edge, so continuous streams are received with no gap.

## Configuration
- `UART_RX_MAJORITY_EN`
  - Defined: each bit value (start, data, stop) is the 2-of-3 majority of samples taken at ticks with `ph`=6, 7 and 8. The decision and state action occur at the `ph`=8 tick, so strobes come 1 tick later.
  - Undefined: a single sample at `ph`=7, with the decision at that tick.

## Test plan
- Send the frame for 0xA3 (start, bits 1,1,0,0,0,1,0,1, stop) at 115200 → `data`=8'hA3, `valid` high for exactly 1 clock, `frame_err`=0, `busy` back to 0.
- Drive the `uart_tx` output, sending 0x00, 0xFF and 0x55 back-to-back → three `valid` pulses with `data` = 0x00, 0xFF, 0x55 in order, and no `frame_err`.
- Pull `rx` low for 4 ticks (~54 clocks) then high → no `valid`, no `frame_err`, and `busy` returns to 0 before `ph` reaches 8.
- Send 0x3C with the stop bit low, then hold `rx` low for 3 bit times → exactly one `frame_err` pulse, `data`=8'h3C, no `valid`. Then send 0x81 after the line returns high → `valid` with `data`=8'h81.
- Assert `resetn`=0 during data bit 4 of a frame → all outputs go to reset values immediately and no strobe follows. After release, a clean 0x5A frame gives `data`=8'h5A.
- With `UART_RX_MAJORITY_EN` defined, send 0x00 with a 1-tick high spike centred on bit 2 → `data`=8'h00. Without the macro, the same spike aligned to `ph`=7 → `data`=8'h04.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, 16x oversampling from a phase-accumulator tick.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at ph 6/7/8.
`timescale 1ns/1ps
module uart_rx #(
  parameter logic [15:0] TICK_INC   = 16'd4832,
  parameter int          OVERSAMPLE = 16
) (
  input  logic       clk_25mhz,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [3:0] PH_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] PH_MID  = 4'(OVERSAMPLE / 2 - 1);

  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_prev;
  logic [15:0] r_acc;
  logic        r_tick;
  logic [3:0]  r_ph;
  logic [2:0]  r_nb;
  logic        r_last;
  logic [7:0]  r_sh;
  logic [1:0]  r_state;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;

  logic [16:0] w_sum;
  logic        w_edge;
  logic        w_wrap;
  logic        w_samp;
  logic        w_bit;

  assign w_sum  = {1'b0, r_acc} + {1'b0, TICK_INC};
  assign w_edge = r_rx_prev & ~r_rx_s2;
  assign w_wrap = r_tick && (r_ph == PH_LAST);

`ifdef UART_RX_MAJORITY_EN
  logic r_s6;
  logic r_s7;

  // Capture the two early votes; the third is taken live at ph 8.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      r_s6 <= 1'b1;
      r_s7 <= 1'b1;
    end else if (r_tick) begin
      if (r_ph == PH_MID - 4'd2) r_s6 <= r_rx_s2;
      if (r_ph == PH_MID - 4'd1) r_s7 <= r_rx_s2;
    end
  end

  assign w_samp = r_tick && (r_ph == PH_MID);
  assign w_bit  = (r_s6 & r_s7) |
                  (r_s6 & r_rx_s2) |
                  (r_s7 & r_rx_s2);
`else
  assign w_samp = r_tick && (r_ph == PH_MID - 4'd1);
  assign w_bit  = r_rx_s2;
`endif

  // Two-flop synchronizer plus previous value for edge detect.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // Free-running accumulator; carry-out is the oversample tick.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      r_acc  <= 16'h0000;
      r_tick <= 1'b0;
    end else begin
      {r_tick, r_acc} <= w_sum;
    end
  end

  // Bit phase: realigned to the start edge, then counts ticks.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      r_ph <= 4'd0;
    end else if (r_state == S_IDLE && w_edge) begin
      r_ph <= 4'd0;
    end else if (r_tick) begin
      r_ph <= r_ph + 4'd1;
    end
  end

  // Frame state machine, shift register and output strobes.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_nb    <= 3'd0;
      r_last  <= 1'b0;
      r_sh    <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge) r_state <= S_START;
        end
        S_START: begin
          if (w_samp) begin
            if (w_bit) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_nb    <= 3'd0;
              r_last  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_samp) begin
            r_sh <= {w_bit, r_sh[7:1]};
            if (r_nb == 3'd7) r_last <= 1'b1;
            else r_nb <= r_nb + 3'd1;
          end
          if (w_wrap && r_last) r_state <= S_STOP;
        end
        S_STOP: begin
          if (w_samp) begin
            r_data  <= r_sh;
            r_valid <= w_bit;
            r_ferr  <= ~w_bit;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);

endmodule
